bin2bcd_seq_conv: RTL and testbench
===================================

Name: bin2bcd_seq_conv

Overview:
Parametrised sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. Successor to the fixed 8-bit/3-digit converter. Adds:
- generic input width and digit count
- explicit start/busy/done handshake
- optional change-triggered auto mode
- overflow detection
Sits between binary counters/arithmetic and the 7-segment display drivers.

Parameters:
BIN_W, 8, binary input width in bits (>=1).
DIGITS, 3, number of BCD output digits (>=1); digit 0 = ones.
AUTO_MODE, 0, 1 = self-start when bin_in differs from last converted value; 0 = convert only on start.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
start  input  1  request conversion of bin_in; sampled only in IDLE.
bin_in  input  BIN_W  unsigned binary value.
busy  output  1  high while conversion in progress.
done  output  1  one-cycle pulse; bcd_out/overflow updated same cycle.
bcd_out  output  4*DIGITS  packed BCD, digit i at [4i+3:4i]; held between conversions.
overflow  output  1  value >= 10^DIGITS; bcd_out then holds value mod 10^DIGITS.

Behaviour:
- Reset: rst_n low at a clock edge returns the block to IDLE, including mid-conversion (conversion aborted, no done). Reset values:
  - busy=0, done=0, bcd_out=0, overflow=0
  - internal scratch and bit counter = 0
  - last-value register = 0
- States: IDLE, SHIFT.
- IDLE:
  - trigger = start, OR (AUTO_MODE=1 AND bin_in != last-value register).
  - On the edge where trigger is seen: capture bin_in into the shift register and into the last-value register, clear the digit scratch, clear the overflow accumulator, set counter=0, busy=1, go to SHIFT.
- SHIFT, each edge:
  - every scratch digit >=5 gets +3 (4-bit, no carry between digits);
  - the whole {digits, bin} register is shifted left by 1;
  - the bit leaving the top digit's MSB is OR-ed into the overflow accumulator;
  - counter increments.
- SHIFT exit: on the edge with counter == BIN_W-1:
  - registered outputs take the post-shift digits and final overflow;
  - done=1, busy=0, return to IDLE.
- Latency: trigger sampled at edge k -> done and new bcd_out visible after edge k+BIN_W. Back-to-back throughput is one conversion per BIN_W+1 cycles.
- done is high for exactly one cycle; otherwise 0.
- Inputs during SHIFT:
  - start is ignored, not queued;
  - bin_in changes are ignored; the captured value is converted;
  - in AUTO_MODE, a change during SHIFT is picked up in IDLE via the last-value compare.
- start while done=1: the block is in IDLE, so start is accepted; busy rises next cycle.
- Width rule: the digit scratch is 4*DIGITS bits; the shifted-out bit is used only for overflow. No intermediate digit ever exceeds 9 after adjust+shift, except the truncated top digit under overflow.
- bcd_out and overflow change only on done cycles or reset.

Optional Feature:
BIN2BCD_SEG_OUT_EN
- When defined, adds output port seg_out [7*DIGITS-1:0], registered and updated on the same edge as bcd_out.
- Segment encoding is active-low abcdefg, digit i at [7i+6:7i]:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- Leading-zero blanking: any digit above 0 that is zero, with all higher digits also zero, is driven 1111111. Digit 0 is never blanked.
- Reset value: digit 0 = 0000001, others 1111111.
- When undefined: port and logic absent; all other behaviour identical.

Test Plan:
- BIN_W=8, DIGITS=3: reset, pulse start with bin_in=255 -> done exactly 8 cycles after the start edge, bcd_out=12'h255, overflow=0, busy high for 8 cycles.
- Defaults: bin_in=0, then 9, then 100, each started on the cycle done pulses -> bcd_out 12'h000, 12'h009, 12'h100; conversions back-to-back every 9 cycles.
- DIGITS=2, bin_in=123 -> bcd_out=8'h23, overflow=1. Then bin_in=99 -> 8'h99, overflow=0.
- Start bin_in=200; pulse start again with bin_in=7 mid-conversion -> single done, bcd_out=12'h200. Assert rst_n=0 mid-conversion on the next run -> no done, all outputs 0.
- AUTO_MODE=1: hold start=0, bin_in 0->42 -> conversion self-starts, bcd_out=12'h042. Hold 42 -> no further done pulses. Change to 43 during SHIFT -> second conversion after return to IDLE yields 12'h043.
- BIN_W=16, DIGITS=5, bin_in=65535 -> bcd_out=20'h65535 after 16 cycles. With BIN2BCD_SEG_OUT_EN, bin_in=7 on defaults -> seg_out = {1111111, 1111111, 0001111}.

Source files
------------

// File: rtl/bin2bcd_seq_conv_if.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_seq_conv_if
//  Brief    : Start/busy/done handshake and result bundle for bin2bcd_seq_conv.
//             Carries seg_out only when BIN2BCD_SEG_OUT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface bin2bcd_seq_conv_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;
`ifdef BIN2BCD_SEG_OUT_EN
  logic [7*DIGITS-1:0]   seg_out;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow, seg_out
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow, seg_out
  );
`else
  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow
  );
`endif
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq_conv.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_seq_conv
//  Brief    : Parametrised shift-and-add-3 binary-to-BCD converter, one bit
//             per clock, with overflow flag and optional auto-start.
//             Optional 7-segment output enabled by BIN2BCD_SEG_OUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module bin2bcd_seq_conv #(
  parameter int BIN_W     = 8,
  parameter int DIGITS    = 3,
  parameter int AUTO_MODE = 0
) (
  input  wire               clk,
  input  wire               rst_n,
  bin2bcd_seq_conv_if.slave bus
);

  localparam int c_dig_w = 4 * DIGITS;
  localparam int c_cat_w = c_dig_w + BIN_W;
  localparam int c_cnt_w = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t               r_state;
  logic [BIN_W-1:0]     r_bin;
  logic [BIN_W-1:0]     r_last;
  logic [c_dig_w-1:0]   r_dig;
  logic                 r_ovf_acc;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic [c_dig_w-1:0]   r_bcd;
  logic                 r_overflow;

  logic                 w_trigger;
  logic                 w_last_bit;
  logic [c_dig_w-1:0]   w_adj;
  logic [c_cat_w:0]     w_shl;
  logic [c_dig_w-1:0]   w_next_dig;
  logic [BIN_W-1:0]     w_next_bin;
  logic                 w_next_ovf;

  assign w_trigger = bus.start || ((AUTO_MODE != 0) && (bus.bin_in != r_last));
  assign w_last_bit = (r_cnt == c_cnt_w'(BIN_W - 1));

  // Per-digit add-3 correction; digits never carry into each other.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    logic [3:0] w_d;
    assign w_d             = r_dig[4*g +: 4];
    assign w_adj[4*g +: 4] = (w_d >= 4'd5) ? (w_d + 4'd3) : w_d;
  end

  // Top bit of the shifted word is what falls off the highest digit.
  assign w_shl      = {w_adj, r_bin, 1'b0};
  assign w_next_dig = w_shl[c_cat_w-1 -: c_dig_w];
  assign w_next_bin = w_shl[BIN_W-1:0];
  assign w_next_ovf = r_ovf_acc | w_shl[c_cat_w];

`ifdef BIN2BCD_SEG_OUT_EN
  localparam logic [7*DIGITS-1:0] c_seg_rst = {(7*DIGITS){1'b1}} & ~((7*DIGITS)'(7'h7E));

  logic [7*DIGITS-1:0]  r_seg;
  logic [7*DIGITS-1:0]  w_seg_next;
  logic [DIGITS:0]      w_hi_zero;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'b0000001;
      4'd1:    f_seg = 7'b1001111;
      4'd2:    f_seg = 7'b0010010;
      4'd3:    f_seg = 7'b0000110;
      4'd4:    f_seg = 7'b1001100;
      4'd5:    f_seg = 7'b0100100;
      4'd6:    f_seg = 7'b0100000;
      4'd7:    f_seg = 7'b0001111;
      4'd8:    f_seg = 7'b0000000;
      4'd9:    f_seg = 7'b0000100;
      default: f_seg = 7'b1111111;
    endcase
  endfunction

  // w_hi_zero[i]: digit i and every digit above it are zero.
  assign w_hi_zero[DIGITS] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    assign w_hi_zero[g] = (w_next_dig[4*g +: 4] == 4'd0) && w_hi_zero[g+1];
    if (g == 0) begin : g_lsd
      assign w_seg_next[6:0] = f_seg(w_next_dig[3:0]);
    end else begin : g_msd
      assign w_seg_next[7*g +: 7] = w_hi_zero[g] ? 7'b1111111 : f_seg(w_next_dig[4*g +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg <= c_seg_rst;
    end else if ((r_state == ST_SHIFT) && w_last_bit) begin
      r_seg <= w_seg_next;
    end
  end

  assign bus.seg_out = r_seg;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_bin      <= '0;
      r_last     <= '0;
      r_dig      <= '0;
      r_ovf_acc  <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            r_bin     <= bus.bin_in;
            r_last    <= bus.bin_in;
            r_dig     <= '0;
            r_ovf_acc <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_dig     <= w_next_dig;
          r_bin     <= w_next_bin;
          r_ovf_acc <= w_next_ovf;
          r_cnt     <= r_cnt + c_cnt_w'(1);
          if (w_last_bit) begin
            r_bcd      <= w_next_dig;
            r_overflow <= w_next_ovf;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.bcd_out  = r_bcd;
  assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq_conv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bin2bcd_seq_conv
//  Brief    : Self-checking bench for bin2bcd_seq_conv (four configurations).
//  Revision : 1.0  initial release
// ============================================================================
module tb_bin2bcd_seq_conv;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bin2bcd_seq_conv_if #(.BIN_W(8),  .DIGITS(3)) if0 ();
  bin2bcd_seq_conv_if #(.BIN_W(8),  .DIGITS(2)) if1 ();
  bin2bcd_seq_conv_if #(.BIN_W(8),  .DIGITS(3)) if2 ();
  bin2bcd_seq_conv_if #(.BIN_W(16), .DIGITS(5)) if3 ();

  bin2bcd_seq_conv #(.BIN_W(8),  .DIGITS(3), .AUTO_MODE(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  bin2bcd_seq_conv #(.BIN_W(8),  .DIGITS(2), .AUTO_MODE(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  bin2bcd_seq_conv #(.BIN_W(8),  .DIGITS(3), .AUTO_MODE(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  bin2bcd_seq_conv #(.BIN_W(16), .DIGITS(5), .AUTO_MODE(0)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits of v packed 4 bits each, digit 0 = ones.
  function automatic logic [63:0] to_bcd(input longint unsigned v, input int nd);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [20:0] seg_of(input logic [11:0] b);
    logic [6:0]  tbl [10];
    logic [20:0] s;
    bit          blank;
    logic [3:0]  d;
    tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    blank = 1'b1;
    s     = '0;
    for (int i = 2; i >= 0; i--) begin
      d = b[4*i +: 4];
      if (d != 4'd0) blank = 1'b0;
      s[7*i +: 7] = (i > 0 && blank) ? 7'b1111111 : tbl[d];
    end
    return s;
  endfunction

  // Reference for u_dut0: a conversion occupies 8 edges after the trigger.
  int          m_left = 0;
  logic [7:0]  m_val  = '0;
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  bit          m_ovf  = 1'b0;
  logic [11:0] m_bcd  = '0;
  bit          chk    = 1'b0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (!rst_n) begin
      m_left = 0;
      m_busy = 1'b0;
      m_bcd  = '0;
      m_ovf  = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_bcd  = 12'(to_bcd(m_val % 1000, 3));
        m_ovf  = (m_val >= 1000);
      end
    end else if (if0.start) begin
      m_val  = if0.bin_in;
      m_left = 8;
      m_busy = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      check("cyc_busy",     64'(if0.busy),     64'(m_busy));
      check("cyc_done",     64'(if0.done),     64'(m_done));
      check("cyc_bcd",      64'(if0.bcd_out),  64'(m_bcd));
      check("cyc_overflow", 64'(if0.overflow), 64'(m_ovf));
`ifdef BIN2BCD_SEG_OUT_EN
      check("cyc_seg",      64'(if0.seg_out),  64'(seg_of(m_bcd)));
`endif
    end
  end

  function automatic bit done_of(input int idx);
    case (idx)
      0:       return if0.done;
      1:       return if1.done;
      2:       return if2.done;
      default: return if3.done;
    endcase
  endfunction

  task automatic go(input int idx, input longint unsigned v);
    case (idx)
      0:       begin if0.bin_in = 8'(v);  if0.start = 1'b1; end
      1:       begin if1.bin_in = 8'(v);  if1.start = 1'b1; end
      2:       if2.bin_in = 8'(v);
      default: begin if3.bin_in = 16'(v); if3.start = 1'b1; end
    endcase
  endtask

  // Returns the number of falling edges until done (0 on timeout).
  task automatic wait_done(input int idx, input int budget, output int cyc);
    cyc = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (i == 1) begin
        if0.start = 1'b0;
        if1.start = 1'b0;
        if3.start = 1'b0;
      end
      if (done_of(idx)) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic count_dones(input int idx, input int n, output int nd);
    nd = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done_of(idx)) nd++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int cyc;
    int nb;
    int nd;
    longint unsigned v;

    if0.start = 1'b0; if0.bin_in = '0;
    if1.start = 1'b0; if1.bin_in = '0;
    if2.start = 1'b0; if2.bin_in = '0;
    if3.start = 1'b0; if3.bin_in = '0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    chk = 1'b1;
    @(negedge clk);
    check("rst_busy0", 64'(if0.busy),     64'd0);
    check("rst_done0", 64'(if0.done),     64'd0);
    check("rst_bcd0",  64'(if0.bcd_out),  64'd0);
    check("rst_ovf0",  64'(if0.overflow), 64'd0);
    check("rst_bcd3",  64'(if3.bcd_out),  64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 255 on the default configuration: latency, busy width, result
    go(0, 255);
    cyc = 0; nb = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) if0.start = 1'b0;
      if (if0.busy) nb++;
      if (if0.done) begin cyc = i; break; end
    end
    check("lat255",  64'(cyc),          64'd9);
    check("busy255", 64'(nb),           64'd8);
    check("bcd255",  64'(if0.bcd_out),  64'h255);
    check("ovf255",  64'(if0.overflow), 64'd0);

    // Back-to-back conversions started on each done cycle
    go(0, 0);
    wait_done(0, 30, cyc);
    check("lat0",   64'(cyc),         64'd9);
    check("bcd0",   64'(if0.bcd_out), 64'h000);
    go(0, 9);
    wait_done(0, 30, cyc);
    check("lat9",   64'(cyc),         64'd9);
    check("bcd9",   64'(if0.bcd_out), 64'h009);
    go(0, 100);
    wait_done(0, 30, cyc);
    check("lat100", 64'(cyc),         64'd9);
    check("bcd100", 64'(if0.bcd_out), 64'h100);

    // start during SHIFT is ignored
    go(0, 200);
    @(negedge clk); if0.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if0.bin_in = 8'd7; if0.start = 1'b1;
    @(negedge clk); if0.start = 1'b0;
    count_dones(0, 15, nd);
    check("ign_dones", 64'(nd),          64'd1);
    check("ign_bcd",   64'(if0.bcd_out), 64'h200);

    // Reset mid-conversion aborts with no done
    go(0, 77);
    @(negedge clk); if0.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(0, 15, nd);
    check("abort_dones", 64'(nd),           64'd0);
    check("abort_busy",  64'(if0.busy),     64'd0);
    check("abort_bcd",   64'(if0.bcd_out),  64'd0);
    check("abort_ovf",   64'(if0.overflow), 64'd0);

`ifdef BIN2BCD_SEG_OUT_EN
    go(0, 7);
    wait_done(0, 30, cyc);
    check("seg7", 64'(if0.seg_out), 64'(21'b1111111_1111111_0001111));
`endif

    // Two digits: overflow truncates to value mod 100
    go(1, 123);
    wait_done(1, 30, cyc);
    check("d2_lat123", 64'(cyc),          64'd9);
    check("d2_bcd123", 64'(if1.bcd_out),  64'h23);
    check("d2_ovf123", 64'(if1.overflow), 64'd1);
    go(1, 99);
    wait_done(1, 30, cyc);
    check("d2_bcd99",  64'(if1.bcd_out),  64'h99);
    check("d2_ovf99",  64'(if1.overflow), 64'd0);
    for (int k = 0; k < 8; k++) begin
      v = longint'($urandom_range(0, 255));
      go(1, v);
      wait_done(1, 30, cyc);
      check("d2_rnd_bcd", 64'(if1.bcd_out),  to_bcd(v % 100, 2));
      check("d2_rnd_ovf", 64'(if1.overflow), 64'(v >= 100));
    end

    // 16-bit input, five digits
    go(3, 65535);
    wait_done(3, 40, cyc);
    check("w16_lat", 64'(cyc),          64'd17);
    check("w16_bcd", 64'(if3.bcd_out),  64'h65535);
    check("w16_ovf", 64'(if3.overflow), 64'd0);
    for (int k = 0; k < 4; k++) begin
      v = longint'($urandom_range(0, 65535));
      go(3, v);
      wait_done(3, 40, cyc);
      check("w16_rnd_bcd", 64'(if3.bcd_out), to_bcd(v, 5));
    end

    // Auto mode: change-triggered conversions
    count_dones(2, 5, nd);
    check("auto_idle", 64'(nd), 64'd0);
    go(2, 42);
    wait_done(2, 30, cyc);
    check("auto_lat42", 64'(cyc),         64'd9);
    check("auto_bcd42", 64'(if2.bcd_out), 64'h042);
    count_dones(2, 20, nd);
    check("auto_hold42", 64'(nd), 64'd0);
    go(2, 50);
    repeat (3) @(negedge clk);
    if2.bin_in = 8'd43;
    wait_done(2, 30, cyc);
    check("auto_bcd50", 64'(if2.bcd_out), 64'h050);
    wait_done(2, 30, cyc);
    check("auto_lat43", 64'(cyc),         64'd9);
    check("auto_bcd43", 64'(if2.bcd_out), 64'h043);
    count_dones(2, 20, nd);
    check("auto_hold43", 64'(nd), 64'd0);

    // Randomized traffic on the default configuration, checked every cycle
    for (int k = 0; k < 400; k++) begin
      if0.bin_in = 8'($urandom);
      if0.start  = ($urandom_range(0, 2) == 0);
      rst_n      = ($urandom_range(0, 96) != 0);
      @(negedge clk);
    end
    if0.start = 1'b0;
    rst_n     = 1'b1;
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
